// File: rtl/bram_stream_reader.sv
// bram_stream_reader: multi-channel strided, multi-pass BRAM read engine feeding AXI-Stream outputs through credit-checked FIFOs.
module bram_stream_reader #(
  parameter int CHANNELS       = 1,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int BRAM_LATENCY   = 2,
  parameter int BRAM_VALID_SIG = 0,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_WIDTH   = 8
) (
  input  logic                           fsm_clk,
  input  logic                           rst_n,
  input  logic                           operation_start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            length,
  input  logic [ADDR_WIDTH-1:0]          stride,
  input  logic [REPEAT_WIDTH-1:0]        repeat_count,
  output logic                           operation_busy,
  output logic                           operation_complete,
  output logic                           operation_error,
  output logic [CHANNELS-1:0]            bram_en,
  output logic [CHANNELS*ADDR_WIDTH-1:0] bram_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0] bram_rddata,
  input  logic [CHANNELS-1:0]            bram_rdack,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNELS-1:0]            m_axis_tvalid,
  input  logic [CHANNELS-1:0]            m_axis_tready,
  output logic [CHANNELS-1:0]            m_axis_tlast,
  output logic [CHANNELS-1:0]            m_axis_tuser
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, ERROR} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] base_r, stride_r, addr_r, cur_base, cur_stride, cur_addr;
  logic [ADDR_WIDTH:0] len_r, idx, cur_len, cur_idx;
  logic [REPEAT_WIDTH-1:0] rep_r, pass, cur_rep, cur_pass;
  // Each channel ring holds reserved (issued) and filled slots: rd..fill buffered, fill..wr outstanding
  logic [AW:0] wr;
  logic [AW:0] rd [CHANNELS];
  logic [AW:0] fill [CHANNELS];
  logic [DATA_WIDTH-1:0] mem [CHANNELS][FIFO_DEPTH];
  logic tag_last [FIFO_DEPTH];
  logic tag_user [FIFO_DEPTH];
  logic [BRAM_LATENCY-1:0] pipe;
  logic [BRAM_LATENCY:0] sh;
  logic [CHANNELS-1:0] pop, cap, credit, orphan;
  logic start_ok, word_last, final_word, go, err, empty;
  always_comb begin
    cur_base = state == IDLE ? base_addr : base_r;
    cur_stride = state == IDLE ? stride : stride_r;
    cur_addr = state == IDLE ? base_addr : addr_r;
    cur_len = state == IDLE ? length : len_r;
    cur_idx = state == IDLE ? '0 : idx;
    cur_rep = state == IDLE ? repeat_count : rep_r;
    cur_pass = state == IDLE ? '0 : pass;
    word_last = cur_idx == cur_len - 1'b1;
    final_word = word_last && cur_pass == cur_rep - 1'b1;
    start_ok = state == IDLE && operation_start && length != '0 && repeat_count != '0;
    sh = {pipe, bram_en[0]};
    empty = 1'b1;
    m_axis_tdata = '0;
    m_axis_tvalid = '0;
    m_axis_tlast = '0;
    m_axis_tuser = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      m_axis_tvalid[c] = fill[c] != rd[c];
      m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH] = mem[c][rd[c][AW-1:0]];
      m_axis_tlast[c] = tag_last[rd[c][AW-1:0]];
      m_axis_tuser[c] = tag_user[rd[c][AW-1:0]];
      pop[c] = (fill[c] != rd[c]) && m_axis_tready[c];
      orphan[c] = bram_rdack[c] && fill[c] == wr;
      cap[c] = BRAM_VALID_SIG != 0 ? bram_rdack[c] && !orphan[c] : sh[BRAM_LATENCY];
      // A slot popped this cycle is already free for the read issued at this edge
      credit[c] = wr - rd[c] - {{AW{1'b0}}, pop[c]} < DEPTH;
      empty = empty && rd[c] == wr;
    end
    err = BRAM_VALID_SIG != 0 && |orphan;
    go = !err && (state == ISSUE || start_ok) && &credit;
  end
  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      operation_busy <= 1'b0;
      operation_complete <= 1'b0;
      operation_error <= 1'b0;
      bram_en <= '0;
      bram_addr <= '0;
      base_r <= '0;
      stride_r <= '0;
      addr_r <= '0;
      len_r <= '0;
      idx <= '0;
      rep_r <= '0;
      pass <= '0;
      wr <= '0;
      pipe <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        rd[c] <= '0;
        fill[c] <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem[c][i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_last[i] <= 1'b0;
        tag_user[i] <= 1'b0;
      end
    end else begin
      bram_en <= {CHANNELS{go}};
      operation_complete <= 1'b0;
      operation_error <= 1'b0;
      pipe <= sh[BRAM_LATENCY-1:0];
      for (int c = 0; c < CHANNELS; c++) begin
        if (cap[c]) begin
          mem[c][fill[c][AW-1:0]] <= bram_rddata[c*DATA_WIDTH +: DATA_WIDTH];
          fill[c] <= fill[c] + 1'b1;
        end
        if (pop[c]) rd[c] <= rd[c] + 1'b1;
      end
      if (start_ok) begin
        base_r <= base_addr;
        stride_r <= stride;
        len_r <= length;
        rep_r <= repeat_count;
      end
      if (go) begin
        bram_addr <= {CHANNELS{cur_addr}};
        tag_last[wr[AW-1:0]] <= word_last;
        tag_user[wr[AW-1:0]] <= final_word;
        wr <= wr + 1'b1;
        addr_r <= word_last ? cur_base : cur_addr + cur_stride;
        idx <= word_last ? '0 : cur_idx + 1'b1;
        pass <= word_last ? cur_pass + 1'b1 : cur_pass;
      end
      if (err || (state == IDLE && operation_start && !start_ok)) begin
        state <= ERROR;
        operation_error <= 1'b1;
        operation_busy <= 1'b0;
        wr <= '0;
        pipe <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          rd[c] <= '0;
          fill[c] <= '0;
        end
      end else if (start_ok) begin
        state <= final_word ? DRAIN : ISSUE;
        operation_busy <= 1'b1;
      end else if (state == ISSUE && go && final_word) begin
        state <= DRAIN;
      end else if (state == DRAIN && empty) begin
        state <= DONE;
        operation_complete <= 1'b1;
        operation_busy <= 1'b0;
      end else if (state == DONE || state == ERROR) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: randomized scoreboard bench for fixed-latency and rdack-driven instances of the reader.
module tb_bram_stream_reader;
  logic clk;
  logic rst_n [2];
  logic start [2];
  logic [7:0] base [2];
  logic [7:0] stride [2];
  logic [7:0] rep [2];
  logic [8:0] len [2];
  logic busy [2];
  logic cmpl [2];
  logic err [2];
  logic [1:0] en [2];
  logic [1:0] tvalid [2];
  logic [1:0] tready [2];
  logic [1:0] tlast [2];
  logic [1:0] tuser [2];
  logic [15:0] addr [2];
  logic [31:0] tdata [2];
  logic [31:0] rddata0, rddata1, p1;
  logic [1:0] rdack1;
  logic inject;
  int rdy_mode [2];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q [4][$];
  logic [7:0] addr_q [2][$];
  logic [47:0] pend [2][$];
  logic held [4];
  logic [17:0] hold_val [4];

  for (genvar g = 0; g < 2; g++) begin : gi
    bram_stream_reader #(
      .CHANNELS(2), .DATA_WIDTH(16), .ADDR_WIDTH(8), .BRAM_LATENCY(2),
      .BRAM_VALID_SIG(g), .FIFO_DEPTH(4), .REPEAT_WIDTH(8)
    ) dut (
      .fsm_clk(clk), .rst_n(rst_n[g]), .operation_start(start[g]),
      .base_addr(base[g]), .length(len[g]), .stride(stride[g]), .repeat_count(rep[g]),
      .operation_busy(busy[g]), .operation_complete(cmpl[g]), .operation_error(err[g]),
      .bram_en(en[g]), .bram_addr(addr[g]),
      .bram_rddata(g == 0 ? rddata0 : rddata1), .bram_rdack(g == 0 ? 2'b00 : rdack1),
      .m_axis_tdata(tdata[g]), .m_axis_tvalid(tvalid[g]), .m_axis_tready(tready[g]),
      .m_axis_tlast(tlast[g]), .m_axis_tuser(tuser[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] word(input int c, input logic [7:0] a);
    return {a ^ 8'(c * 60 + 17), a + 8'h5B};
  endfunction

  function automatic logic [63:0] outs(input int g);
    return 64'({busy[g], cmpl[g], err[g], en[g], addr[g], tdata[g], tvalid[g], tlast[g], tuser[g]});
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, got, want, cyc);
    end
  endtask

  // Fixed two-cycle BRAM: address in cycle N, data visible in cycle N+2
  always @(posedge clk) begin
    p1 <= {word(1, addr[0][15:8]), word(0, addr[0][7:0])};
    rddata0 <= p1;
  end

  // Acknowledged BRAM: each read returns in order after 1..5 cycles
  initial forever begin
    logic [47:0] e;
    logic [31:0] due;
    @(negedge clk);
    for (int c = 0; c < 2; c++) if (en[1][c]) begin
      due = 32'(cyc) + 32'($urandom_range(1, 5));
      if (pend[c].size() > 0) begin
        e = pend[c][pend[c].size()-1];
        if (e[47:16] >= due) due = e[47:16] + 1;
      end
      pend[c].push_back({due, word(c, addr[1][c*8 +: 8])});
    end
    for (int c = 0; c < 2; c++) begin
      rdack1[c] = 1'b0;
      if (pend[c].size() > 0) begin
        e = pend[c][0];
        if (e[47:16] <= 32'(cyc)) begin
          e = pend[c].pop_front();
          rdack1[c] = 1'b1;
          rddata1[c*16 +: 16] = e[15:0];
        end
      end
    end
    rdack1[0] = rdack1[0] | inject;
  end

  initial forever begin
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++)
      tready[g] = rdy_mode[g] == 0 ? 2'b11 : rdy_mode[g] == 1 ? 2'($urandom) : 2'b01;
  end

  initial forever begin
    logic [17:0] cur, e;
    logic [7:0] a;
    int i;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      if (!rst_n[g]) begin
        held[g*2] = 1'b0;
        held[g*2+1] = 1'b0;
      end else begin
        if (en[g] != 2'b00) begin
          chk("en_lockstep", en[g], 2'b11);
          chk("addr_expected", addr_q[g].size() > 0, 1);
          if (addr_q[g].size() > 0) begin
            a = addr_q[g].pop_front();
            chk("addr_ch0", addr[g][7:0], a);
            chk("addr_ch1", addr[g][15:8], a);
          end
        end
        for (int c = 0; c < 2; c++) begin
          i = g * 2 + c;
          cur = {tdata[g][c*16 +: 16], tlast[g][c], tuser[g][c]};
          if (held[i]) chk("axis_hold", {tvalid[g][c], cur}, {1'b1, hold_val[i]});
          if (tvalid[g][c] && tready[g][c]) begin
            chk("word_expected", exp_q[i].size() > 0, 1);
            if (exp_q[i].size() > 0) begin
              e = exp_q[i].pop_front();
              chk("stream_word", cur, e);
            end
          end
          held[i] = tvalid[g][c] && !tready[g][c];
          hold_val[i] = cur;
        end
      end
    end
  end

  task automatic run(input int g, input logic [7:0] b, input logic [8:0] l, input logic [7:0] s, input logic [7:0] r);
    for (int p = 0; p < int'(r); p++)
      for (int k = 0; k < int'(l); k++) begin
        logic [7:0] a;
        a = 8'(int'(b) + k * int'(s));
        addr_q[g].push_back(a);
        for (int c = 0; c < 2; c++)
          exp_q[g*2+c].push_back({word(c, a), k == int'(l) - 1, k == int'(l) - 1 && p == int'(r) - 1});
      end
    @(negedge clk);
    base[g] = b;
    len[g] = l;
    stride[g] = s;
    rep[g] = r;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    if (l != 0 && r != 0) chk("busy_after_start", busy[g], 1);
    else begin
      chk("error_after_start", err[g], 1);
      chk("no_busy_on_error", busy[g], 0);
    end
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while (!cmpl[g] && !err[g] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("complete_pulse", cmpl[g], 1);
    chk("busy_low_at_done", busy[g], 0);
    @(negedge clk);
    chk("complete_one_cycle", cmpl[g], 0);
    chk("sb_drained", exp_q[g*2].size() + exp_q[g*2+1].size() + addr_q[g].size(), 0);
  endtask

  initial begin
    int n;
    inject = 1'b0;
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0;
      start[g] = 1'b0;
      base[g] = '0;
      len[g] = '0;
      stride[g] = '0;
      rep[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) chk("reset_outputs", outs(g), 0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 8'h10, 9'd4, 8'd2, 8'd1);
    chk("first_en_cycle1", en[0], 2'b11);
    n = 1;
    while (!tvalid[0][0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("first_tvalid_cycle", n, 4);
    wait_done(0);

    run(0, 8'h20, 9'd3, 8'd1, 8'd3);
    wait_done(0);

    rdy_mode[0] = 2;
    run(0, 8'h40, 9'd12, 8'd3, 8'd1);
    n = 1;
    repeat (19) begin
      @(negedge clk);
      n += int'(en[0][0]);
    end
    chk("credit_stall_issues", n, 4);
    chk("ch0_drained_4", exp_q[0].size(), 8);
    chk("ch1_holds_all", exp_q[1].size(), 12);
    rdy_mode[0] = 0;
    wait_done(0);

    run(0, 8'h00, 9'd0, 8'd1, 8'd1);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(en[0][0]) + int'(err[0]);
    end
    chk("len0_no_en_single_error", n, 0);
    run(0, 8'h00, 9'd3, 8'd1, 8'd0);
    repeat (3) @(negedge clk);

    run(0, 8'h80, 9'd20, 8'd1, 8'd2);
    repeat (5) @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    chk("reset_midop", outs(0), 0);
    exp_q[0].delete();
    exp_q[1].delete();
    addr_q[0].delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    run(0, 8'hFE, 9'd4, 8'd1, 8'd1);
    wait_done(0);

    rdy_mode[0] = 1;
    repeat (6) begin
      run(0, 8'($urandom), 9'($urandom_range(1, 10)), 8'($urandom), 8'($urandom_range(1, 3)));
      wait_done(0);
    end

    run(1, 8'h10, 9'd4, 8'd2, 8'd1);
    wait_done(1);
    rdy_mode[1] = 1;
    repeat (6) begin
      run(1, 8'($urandom), 9'($urandom_range(1, 10)), 8'($urandom), 8'($urandom_range(1, 3)));
      wait_done(1);
    end

    repeat (4) @(negedge clk);
    @(posedge clk);
    inject = 1'b1;
    @(posedge clk);
    inject = 1'b0;
    @(negedge clk);
    chk("spurious_rdack_error", err[1], 1);
    chk("spurious_no_busy", busy[1], 0);
    @(negedge clk);
    chk("error_one_cycle", err[1], 0);
    run(1, 8'h30, 9'd5, 8'd4, 8'd2);
    wait_done(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
endmodule
